bank_router: RTL and testbench

//  Registered, handshaked bank selector between the POY-row input line buffers and the PE array.

---
 rtl/bank_router.sv | 116 +++++++++++
 tb/tb_bank_router.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_router.sv
// bank_router: registered, handshaked selector forwarding one of POY input banks per beat
// Optional feature: define ROUTER_PAD_EN to add pad_mask (beats from masked banks emit zeros).
// Ports:
//   clk, rst                                   clock, synchronous active-high reset
//   cfg_start, cfg_rot, cfg_bank, cfg_len      run setup, latched on cfg_start while idle
//   in_valid, in_ready, idata                  input handshake, POY banks of BUFW lanes
//   out_valid, out_ready, odata, out_bank,     registered output beat with its bank index
//   out_last                                   and final-beat flag
//   busy, done, err                            running, end-of-run pulse, bad-bank pulse
//   pad_mask (ROUTER_PAD_EN only)              per-bank zero-pad select, latched at start
module bank_router #(
   parameter int DW = 8,
   parameter int POY = 3,
   parameter int BUFW = 32,
   localparam int BANKW = $clog2(POY)
) (
   input  logic                                clk,
   input  logic                                rst,
`ifdef ROUTER_PAD_EN
   input  logic [POY-1:0]                      pad_mask,
`endif
   input  logic                                cfg_start,
   input  logic                                cfg_rot,
   input  logic [BANKW-1:0]                    cfg_bank,
   input  logic [15:0]                         cfg_len,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [POY-1:0][BUFW-1:0][DW-1:0]    idata,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [BUFW-1:0][DW-1:0]             odata,
   output logic [BANKW-1:0]                    out_bank,
   output logic                                out_last,
   output logic                                busy,
   output logic                                done,
   output logic                                err
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state;
   logic rot;
   logic [BANKW-1:0] cur_bank;
   logic [15:0] len;
   logic [15:0] beat_cnt;
   logic in_acc;
   logic out_acc;
   logic last_beat;
   logic [BUFW-1:0][DW-1:0] sel;
`ifdef ROUTER_PAD_EN
   logic [POY-1:0] pad;
   assign sel = pad[cur_bank] ? '0 : idata[cur_bank];
`else
   assign sel = idata[cur_bank];
`endif
   // no skid buffer: a new beat is taken only when the output register is free or draining
   assign in_ready = state == RUN && (!out_valid || out_ready);
   assign in_acc = in_valid && in_ready;
   assign out_acc = out_valid && out_ready;
   assign last_beat = beat_cnt == len - 16'd1;
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rot <= 1'b0;
         cur_bank <= '0;
         len <= '0;
         beat_cnt <= '0;
         odata <= '0;
         out_bank <= '0;
         out_valid <= 1'b0;
         out_last <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
`ifdef ROUTER_PAD_EN
         pad <= '0;
`endif
      end else begin
         done <= 1'b0;
         err <= 1'b0;
         if (in_acc) begin
            odata <= sel;
            out_bank <= cur_bank;
            out_valid <= 1'b1;
            out_last <= last_beat;
            beat_cnt <= beat_cnt + 16'd1;
            if (rot) cur_bank <= cur_bank == BANKW'(POY - 1) ? '0 : cur_bank + BANKW'(1);
         end else if (out_acc) begin
            // odata is held; only the qualifiers drop
            out_valid <= 1'b0;
            out_last <= 1'b0;
         end
         case (state)
            IDLE: if (cfg_start) begin
               // bad bank is checked first so err wins over a zero-length run
               if (int'(cfg_bank) >= POY) err <= 1'b1;
               else if (cfg_len == 16'd0) done <= 1'b1;
               else begin
                  state <= RUN;
                  rot <= cfg_rot;
                  cur_bank <= cfg_bank;
                  len <= cfg_len;
                  beat_cnt <= '0;
`ifdef ROUTER_PAD_EN
                  pad <= pad_mask;
`endif
               end
            end
            RUN: if (in_acc && last_beat) state <= DRAIN;
            DRAIN: if (out_acc && out_last) begin
               state <= IDLE;
               done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bank_router.sv
// tb_bank_router: scoreboard bench for bank_router (fixed, rotate, backpressure, errors, reset, pad)
module tb_bank_router;
   localparam int DW = 8;
   localparam int POY = 3;
   localparam int BUFW = 32;
   localparam int BANKW = 2;
   typedef struct packed {
      logic [BUFW-1:0][DW-1:0] d;
      logic [BANKW-1:0] b;
      logic l;
   } beat_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cfg_start = 1'b0;
   logic cfg_rot = 1'b0;
   logic [BANKW-1:0] cfg_bank = '0;
   logic [15:0] cfg_len = '0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [POY-1:0][BUFW-1:0][DW-1:0] idata = '0;
   logic out_valid;
   logic out_ready = 1'b1;
   logic [BUFW-1:0][DW-1:0] odata;
   logic [BANKW-1:0] out_bank;
   logic out_last;
   logic busy;
   logic done;
   logic err;
   logic [POY-1:0] pad_mask = '0;
   int checks = 0;
   int errors = 0;
   beat_t sb[$];
   beat_t e;
   logic hold_pend = 1'b0;
   logic last_pend = 1'b0;
   logic [BUFW-1:0][DW-1:0] hold_d;
   logic [BANKW-1:0] hold_b;

   always #5 clk = ~clk;

   bank_router #(.DW(DW), .POY(POY), .BUFW(BUFW)) dut (
      .clk(clk),
      .rst(rst),
`ifdef ROUTER_PAD_EN
      .pad_mask(pad_mask),
`endif
      .cfg_start(cfg_start),
      .cfg_rot(cfg_rot),
      .cfg_bank(cfg_bank),
      .cfg_len(cfg_len),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .idata(idata),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .odata(odata),
      .out_bank(out_bank),
      .out_last(out_last),
      .busy(busy),
      .done(done),
      .err(err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: pops the scoreboard on every output transfer and checks hold/done timing
   always @(negedge clk) begin
      if (hold_pend) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_bank", out_bank, hold_b);
         checks++;
         if (odata !== hold_d) begin
            errors++;
            $display("FAIL hold_data: got %h expected %h", odata, hold_d);
         end
      end
      if (last_pend) chk("done_after_last", done, 1);
      if (!rst && out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got bank %0d expected no beat", out_bank);
         end else begin
            e = sb.pop_front();
            chk("out_bank", out_bank, e.b);
            chk("out_last", out_last, e.l);
            checks++;
            if (odata !== e.d) begin
               errors++;
               $display("FAIL odata bank %0d: got %h expected %h", e.b, odata, e.d);
            end
         end
      end
      hold_pend = !rst && out_valid && !out_ready;
      hold_d = odata;
      hold_b = out_bank;
      last_pend = !rst && out_valid && out_ready && out_last;
   end

   task automatic run(input int bank, input bit rot, input int len, input int stall_at, input int abort_at);
      int b = bank;
      int n = 0;
      int cyc = 0;
      logic [POY-1:0] pm;
      beat_t x;
      cfg_start = 1'b1;
      cfg_bank = BANKW'(bank);
      cfg_rot = rot;
      cfg_len = 16'(len);
`ifdef ROUTER_PAD_EN
      pm = pad_mask;
`else
      pm = '0;
`endif
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      cfg_bank = BANKW'((bank + 1) % POY);
      cfg_rot = ~rot;
      cfg_len = 16'd1;
      pad_mask = ~pad_mask;
      while (n < len && cyc < 100 && !(abort_at >= 0 && n == abort_at)) begin
         for (int k = 0; k < POY; k++)
            for (int j = 0; j < BUFW; j++)
               idata[k][j] = DW'($urandom);
         in_valid = 1'b1;
         out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
         cfg_start = cyc == 2;
         @(negedge clk);
         if (in_valid && in_ready) begin
            x.d = pm[b] ? '0 : idata[b];
            x.b = BANKW'(b);
            x.l = n == len - 1;
            sb.push_back(x);
            n++;
            if (rot) b = (b + 1) % POY;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      cfg_start = 1'b0;
      in_valid = 1'b0;
      if (cyc >= 100) chk("run_budget", 64'(n), 64'(len));
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      out_ready = 1'b1;
      while (!done && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk({name, "_done"}, done, 1);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_sb_empty"}, 64'(sb.size()), 0);
      @(posedge clk);
      #1;
      chk({name, "_done_pulse"}, done, 0);
   endtask

   task automatic check_reset(input string name);
      chk({name, "_valid"}, out_valid, 0);
      chk({name, "_last"}, out_last, 0);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_done"}, done, 0);
      chk({name, "_err"}, err, 0);
      chk({name, "_bank"}, out_bank, 0);
      checks++;
      if (odata !== '0) begin
         errors++;
         $display("FAIL %s_odata: got %h expected 0", name, odata);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      run(1, 0, 4, -1, -1);
      wait_done("fixed");
      run(2, 1, 5, -1, -1);
      wait_done("rotate");
      run(0, 1, 7, 2, -1);
      wait_done("stall");
      cfg_bank = 2'd3;
      cfg_len = 16'd4;
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      chk("badbank_err", err, 1);
      chk("badbank_busy", busy, 0);
      @(posedge clk);
      #1;
      chk("badbank_err_pulse", err, 0);
      chk("badbank_busy2", busy, 0);
      cfg_bank = 2'd0;
      cfg_len = 16'd0;
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      chk("len0_done", done, 1);
      chk("len0_busy", busy, 0);
      chk("len0_valid", out_valid, 0);
      @(posedge clk);
      #1;
      chk("len0_done_pulse", done, 0);
      chk("len0_valid2", out_valid, 0);
      cfg_bank = 2'd3;
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      chk("both_err", err, 1);
      chk("both_done", done, 0);
      run(0, 1, 6, -1, 2);
      rst = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      check_reset("midrst");
      rst = 1'b0;
      sb.delete();
      out_ready = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("midrst_no_done", done, 0);
         chk("midrst_no_valid", out_valid, 0);
      end
      run(1, 1, 6, -1, -1);
      wait_done("after_rst");
`ifdef ROUTER_PAD_EN
      pad_mask = 3'b001;
      run(0, 1, 3, -1, -1);
      wait_done("pad");
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
